// File: rtl/cv32e40s_rr_arbiter_pkg.sv
// Shared types for the round-robin arbiter: the two-state transaction FSM
// encoding and a width helper for the watchdog counter.
package cv32e40s_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rr_arb_state_e;

  // Watchdog counter width; a disabled watchdog still gets a 1-bit counter.
  function automatic int cnt_width(input int timeout);
    return (timeout <= 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cv32e40s_rr_arbiter_if.sv
// Bundle of requester and resource signals around the round-robin arbiter.
// master = arbiter side, slave = requesters plus resource side.
interface cv32e40s_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDXW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic               valid_o;
  logic [IDXW-1:0]    idx_o;
  logic               ready_i;
  logic               done_i;
  logic               busy_o;
  logic               timeout_o;

  modport master (
    input  req_i, ready_i, done_i,
    output gnt_o, valid_o, idx_o, busy_o, timeout_o
  );

  modport slave (
    output req_i, ready_i, done_i,
    input  gnt_o, valid_o, idx_o, busy_o, timeout_o
  );
endinterface

// File: rtl/cv32e40s_ff_one.sv
// Find-first-one encoder: index of the lowest set bit, 0 when no bit is set,
// so the result never exceeds LEN-1 even when LEN is not a power of two.
module cv32e40s_ff_one #(
  parameter int LEN = 4
) (
  input  logic [LEN-1:0]         in_vec,
  output logic [$clog2(LEN)-1:0] first_idx
);
  localparam int IW = $clog2(LEN);

  always_comb begin
    first_idx = '0;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (in_vec[i]) first_idx = IW'(i);
    end
  end
endmodule

// File: rtl/cv32e40s_rr_arbiter.sv
// Round-robin arbiter sharing one single-outstanding resource between
// NUM_REQ requesters, with an optional watchdog on the outstanding transaction.
module cv32e40s_rr_arbiter
  import cv32e40s_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  cv32e40s_rr_arbiter_if.master  bus,
  output rr_arb_state_e          state_dbg
);
  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CW   = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_REQ - 1);

  rr_arb_state_e      state_q, state_d;
  logic [IDXW-1:0]    last_q, owner_q;
  logic [CW-1:0]      cnt_q;

  logic [NUM_REQ-1:0] req, mask, masked, sel_vec, gnt;
  logic [IDXW-1:0]    winner, idx;
  logic               valid, hs, busy, expire, timeout;

  assign req = bus.req_i;

  // Priority starts strictly above the last winner; fall back to the raw
  // request vector when nothing is pending above it.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i > int'(last_q));
    end
  end

  assign masked  = req & mask;
  assign sel_vec = (|masked) ? masked : req;

  cv32e40s_ff_one #(
    .LEN (NUM_REQ)
  ) u_ff_one (
    .in_vec    (sel_vec),
    .first_idx (winner)
  );

  // Handshake: fires when valid && ready in IDLE. valid/idx are recomputed
  // every cycle, so the presented index may change before acceptance.
  assign valid  = (state_q == IDLE) && (|req);
  assign hs     = valid && bus.ready_i;
  assign busy   = (state_q == BUSY);
  assign expire = busy && (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        owner_q <= winner;
        last_q  <= winner;
        cnt_q   <= '0;
      end else if (busy && !bus.done_i && !expire && (cnt_q != {CW{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (hs) state_d = BUSY;
      BUSY: if (bus.done_i || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt     = '0;
    idx     = winner;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          gnt[i] = hs && (winner == IDXW'(i));
        end
      end
      BUSY: begin
        idx     = owner_q;
        timeout = expire && !bus.done_i;
      end
      default: ;
    endcase
  end

  assign bus.gnt_o     = gnt;
  assign bus.valid_o   = valid;
  assign bus.idx_o     = idx;
  assign bus.busy_o    = busy;
  assign bus.timeout_o = timeout;
  assign state_dbg     = state_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_hs:     assert property (@(posedge clk) disable iff (rst) (gnt != '0) |-> hs);
  a_busy_valid: assert property (@(posedge clk) disable iff (rst) !(busy && valid));

endmodule

// File: tb/tb_cv32e40s_rr_arbiter.sv
// Directed bench for the round-robin arbiter: rotation, fallback, stall,
// watchdog, done/timeout collision and reset during a transaction.
module tb_cv32e40s_rr_arbiter;
  import cv32e40s_rr_arbiter_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 3;

  logic          clk;
  logic          rst;
  rr_arb_state_e state_dbg;
  int            n_cmp;
  int            n_bad;

  cv32e40s_rr_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  cv32e40s_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic rdy, input logic dn);
    bus.req_i   = req;
    bus.ready_i = rdy;
    bus.done_i  = dn;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    tick;
    tick;
    n_cmp++;
    if (bus.gnt_o !== 4'b0 || bus.valid_o !== 1'b0 || bus.idx_o !== 2'd0 ||
        bus.busy_o !== 1'b0 || bus.timeout_o !== 1'b0 || state_dbg !== IDLE) begin
      n_bad++;
      $display("FAIL reset_outputs: gnt=%b valid=%b idx=%0d busy=%b to=%b state=%0d, required all zero / IDLE",
               bus.gnt_o, bus.valid_o, bus.idx_o, bus.busy_o, bus.timeout_o, state_dbg);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_rotation;
    logic [3:0] exp_gnt [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 1'b1, 1'b0);
      n_cmp++;
      if (bus.gnt_o !== exp_gnt[k] || bus.idx_o !== 2'(k % 4)) begin
        n_bad++;
        $display("FAIL rotation_grant%0d: gnt=%b idx=%0d, required gnt=%b idx=%0d",
                 k, bus.gnt_o, bus.idx_o, exp_gnt[k], k % 4);
      end
      tick;
      drive(4'b1111, 1'b1, 1'b1);
      n_cmp++;
      if (bus.busy_o !== 1'b1 || bus.gnt_o !== 4'b0 || bus.valid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL rotation_busy%0d: busy=%b gnt=%b valid=%b, required 1 0000 0",
                 k, bus.busy_o, bus.gnt_o, bus.valid_o);
      end
      tick;
    end
    drive(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_fallback;
    // last winner is 0; grant 1 so that last becomes 1
    drive(4'b0010, 1'b1, 1'b0);
    tick;
    drive(4'b0000, 1'b0, 1'b1);
    tick;
    drive(4'b0001, 1'b1, 1'b0);
    n_cmp++;
    if (bus.gnt_o !== 4'b0001 || bus.idx_o !== 2'd0) begin
      n_bad++;
      $display("FAIL fallback_grant: gnt=%b idx=%0d, required 0001 idx 0", bus.gnt_o, bus.idx_o);
    end
    tick;
    drive(4'b0000, 1'b0, 1'b1);
    tick;
    // last is now 0, so with all requesting index 1 wins
    drive(4'b1111, 1'b1, 1'b0);
    n_cmp++;
    if (bus.gnt_o !== 4'b0010) begin
      n_bad++;
      $display("FAIL fallback_last_updated: gnt=%b, required 0010", bus.gnt_o);
    end
    tick;
    drive(4'b0000, 1'b0, 1'b1);
    tick;
    drive(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_stall;
    int pulses;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      drive(4'b0100, 1'b0, 1'b0);
      n_cmp++;
      if (bus.valid_o !== 1'b1 || bus.idx_o !== 2'd2 || bus.gnt_o !== 4'b0) begin
        n_bad++;
        $display("FAIL stall_wait%0d: valid=%b idx=%0d gnt=%b, required 1 2 0000",
                 c, bus.valid_o, bus.idx_o, bus.gnt_o);
      end
      if (bus.gnt_o !== 4'b0) pulses++;
      tick;
    end
    drive(4'b0100, 1'b1, 1'b0);
    n_cmp++;
    if (bus.valid_o !== 1'b1 || bus.idx_o !== 2'd2 || bus.gnt_o !== 4'b0100) begin
      n_bad++;
      $display("FAIL stall_accept: valid=%b idx=%0d gnt=%b, required 1 2 0100",
               bus.valid_o, bus.idx_o, bus.gnt_o);
    end
    tick;
    drive(4'b0000, 1'b1, 1'b0);
    n_cmp++;
    if (bus.busy_o !== 1'b1 || bus.idx_o !== 2'd2 || pulses != 0) begin
      n_bad++;
      $display("FAIL stall_busy: busy=%b idx=%0d early_pulses=%0d, required 1 2 0",
               bus.busy_o, bus.idx_o, pulses);
    end
    drive(4'b0000, 1'b0, 1'b1);
    tick;
    drive(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    drive(4'b0001, 1'b1, 1'b0);
    tick;
    drive(4'b0000, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      n_cmp++;
      if (bus.busy_o !== 1'b1 || bus.timeout_o !== (c == 3)) begin
        n_bad++;
        $display("FAIL timeout_cycle%0d: busy=%b timeout=%b, required 1 %0d",
                 c, bus.busy_o, bus.timeout_o, (c == 3));
      end
      tick;
    end
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.timeout_o !== 1'b0 || state_dbg !== IDLE) begin
      n_bad++;
      $display("FAIL timeout_return: busy=%b timeout=%b state=%0d, required 0 0 IDLE",
               bus.busy_o, bus.timeout_o, state_dbg);
    end
  endtask

  task automatic test_done_vs_timeout;
    drive(4'b0001, 1'b1, 1'b0);
    tick;
    drive(4'b0000, 1'b0, 1'b0);
    tick;
    tick;
    drive(4'b0000, 1'b0, 1'b1);
    n_cmp++;
    if (bus.busy_o !== 1'b1 || bus.timeout_o !== 1'b0) begin
      n_bad++;
      $display("FAIL collision_no_timeout: busy=%b timeout=%b, required 1 0",
               bus.busy_o, bus.timeout_o);
    end
    tick;
    drive(4'b0000, 1'b0, 1'b0);
    n_cmp++;
    if (bus.busy_o !== 1'b0 || state_dbg !== IDLE) begin
      n_bad++;
      $display("FAIL collision_return: busy=%b state=%0d, required 0 IDLE", bus.busy_o, state_dbg);
    end
  endtask

  task automatic test_reset_mid_busy;
    drive(4'b0100, 1'b1, 1'b0);
    tick;
    drive(4'b0000, 1'b0, 1'b0);
    n_cmp++;
    if (bus.busy_o !== 1'b1 || bus.idx_o !== 2'd2) begin
      n_bad++;
      $display("FAIL rst_busy_owner: busy=%b idx=%0d, required 1 2", bus.busy_o, bus.idx_o);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.idx_o !== 2'd0 || bus.gnt_o !== 4'b0 ||
        bus.valid_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async_clear: busy=%b idx=%0d gnt=%b valid=%b to=%b, required all zero",
               bus.busy_o, bus.idx_o, bus.gnt_o, bus.valid_o, bus.timeout_o);
    end
    tick;
    rst = 1'b0;
    drive(4'b1111, 1'b1, 1'b0);
    n_cmp++;
    if (bus.gnt_o !== 4'b0001 || bus.idx_o !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_first_grant: gnt=%b idx=%0d, required 0001 0", bus.gnt_o, bus.idx_o);
    end
    tick;
    drive(4'b0000, 1'b0, 1'b1);
    tick;
    drive(4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bus.req_i   = '0;
    bus.ready_i = 1'b0;
    bus.done_i  = 1'b0;
    test_reset;
    test_rotation;
    test_fallback;
    test_stall;
    test_timeout;
    test_done_vs_timeout;
    test_reset_mid_busy;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cv32e40s_rr_arbiter.md
Name: cv32e40s_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-outstanding resource between NUM_REQ requesters. Example resources: a shared bus port, or a multi-cycle unit such as a divider.
- A rotating priority mask selects the next winner. The find-first-one priority encoder (sub-module cv32e40s_ff_one) picks the winner from the masked request vector.
- The winner holds the resource from acceptance until the resource signals completion. An optional watchdog flags a hung transaction.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..32.
- TIMEOUT, 255, maximum BUSY cycles before error; 0 disables the watchdog.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester request level. Held until that requester's gnt_o pulse.
- gnt_o  output  NUM_REQ  one-hot grant pulse, asserted in the acceptance cycle.
- valid_o  output  1  request towards the resource.
- idx_o  output  $clog2(NUM_REQ)  requester index presented with valid_o and held through BUSY.
- ready_i  input  1  resource accepts; the handshake fires when valid_o && ready_i.
- done_i  input  1  resource completion pulse; sampled only in BUSY.
- busy_o  output  1  high while a transaction is outstanding.
- timeout_o  output  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Reset values:
  - state = IDLE, last_q = NUM_REQ-1, owner_q = 0, cnt_q = 0.
  - Outputs: gnt_o = 0, valid_o = 0, idx_o = 0, busy_o = 0, timeout_o = 0.
- Winner selection (combinational, in IDLE only):
  - mask = bits strictly above last_q; masked = req_i & mask.
  - If masked is nonzero, winner = ff_one(masked); otherwise winner = ff_one(req_i).
  - Use two ff_one instances, or one instance with a muxed input.
  - last_q = NUM_REQ-1 gives an empty mask, so index 0 has first priority after reset.
- IDLE state:
  - valid_o = |req_i; idx_o = winner.
  - On a handshake: gnt_o[winner] = 1 for that cycle, owner_q <= winner, last_q <= winner, cnt_q <= 0, go to BUSY.
  - With no handshake, no state changes. The winner is re-evaluated every cycle, so a new higher-priority request may displace the presented index before acceptance (no valid stability guarantee before handshake).
- BUSY state:
  - valid_o = 0, gnt_o = 0, busy_o = 1, idx_o = owner_q.
  - done_i = 1: go to IDLE. The next arbitration starts the following cycle, so there is one bubble per transaction. Back-to-back grants are therefore at best one every two cycles.
  - TIMEOUT != 0 and cnt_q == TIMEOUT-1 with no done_i: pulse timeout_o and go to IDLE (transaction abandoned). Otherwise cnt_q increments and saturates.
  - done_i and timeout in the same cycle: done wins and timeout_o stays 0.
- done_i in IDLE is ignored. ready_i in BUSY is ignored.
- Fairness: with all requests held, grants rotate 0,1,...,NUM_REQ-1,0... Any continuously asserted request is granted within NUM_REQ transactions.
- A requester dropping req_i in IDLE before its grant is legal and simply withdraws it. Dropping it in BUSY has no effect.
- Reset asserted mid-BUSY returns immediately to the reset values; no completion is reported.
- NUM_REQ not a power of two: ff_one handles the padding. idx_o never exceeds NUM_REQ-1.
- Assertions:
  - gnt_o is one-hot or zero.
  - gnt_o is nonzero implies the handshake fired.
  - busy_o and valid_o are never both high.

Decomposition:
- No package typedefs are required beyond a local state enum (IDLE, BUSY). If other arbiters reuse the enum, place it as rr_arb_state_e in cv32e40s_pkg.
- Sub-module: cv32e40s_ff_one, with LEN = NUM_REQ. This is the only instantiated child.
- The counter width is $clog2(TIMEOUT+1), with a minimum of 1.

Test Plan:
- Reset, then req_i = 4'b1111 with ready_i always 1 and done_i one cycle after each grant → gnt_o = 0001, 0010, 0100, 1000, 0001 on alternate cycles; idx_o = 0,1,2,3,0.
- last_q = 1 and req_i = 4'b0001 → the masked vector is empty, so the fallback applies: gnt_o = 0001 and last_q becomes 0.
- IDLE, req_i = 4'b0100, ready_i = 0 for 5 cycles, then 1 → valid_o high for 6 cycles with idx_o = 2; a single gnt_o pulse = 0100 in cycle 6; busy_o goes high the next cycle.
- BUSY with TIMEOUT = 3 and done_i never asserted → timeout_o pulses on the 3rd BUSY cycle; returns to IDLE; busy_o = 0 the next cycle.
- BUSY, done_i asserted in the same cycle the counter expires → no timeout_o pulse; normal return to IDLE.
- rst asserted during BUSY with owner 2 → outputs zero immediately; after release with req_i = 4'b1111, the first grant goes to index 0.
